pwm_cntr: RTL and testbench



---
 rtl/pwm_cntr.sv | 72 +++++++
 tb/tb_pwm_cntr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_cntr.sv
// rtl/pwm_cntr.sv - free-running PWM generator with programmable frequency and per-mille duty
// Only clk is needed: an internal step prescaler derives the 1/1000-period step.
module pwm_cntr #(
   parameter int SYS_FREQ   = 125,
   parameter int DUTY_STEPS = 1000
) (
   input  logic        clk,
   input  logic        reset_p,
   output logic        pwm,
   input  logic [13:0] pwm_freq,
   input  logic [9:0]  duty
);

   localparam logic [26:0] REAL_SYS_FREQ = 27'(SYS_FREQ * 1_000_000);
   localparam logic [26:0] STEPS_27      = 27'(DUTY_STEPS);
   localparam logic [9:0]  DUTY_MAX      = 10'(DUTY_STEPS);
   localparam logic [9:0]  DUTY_LAST     = 10'(DUTY_STEPS - 1);

   logic [26:0] freq_x_steps;
   logic [26:0] divisor;
   logic [26:0] step_quot;
   logic [26:0] step_len;
   logic [26:0] step_cnt_q, step_cnt_d;
   logic [9:0]  duty_cnt_q, duty_cnt_d;
   logic [9:0]  duty_eff;
   logic        pwm_q, pwm_d;
   logic        freq_off;
   logic        tick;

   // The divisor is steered away from zero when disabled; its quotient is unused then.
   always_comb begin
      freq_off     = (pwm_freq == 14'd0);
      freq_x_steps = 27'(pwm_freq) * STEPS_27;
      divisor      = freq_off ? STEPS_27 : freq_x_steps;
      step_quot    = REAL_SYS_FREQ / divisor;
      step_len     = (step_quot == 27'd0) ? 27'd1 : step_quot;
      duty_eff     = (duty >= DUTY_MAX) ? DUTY_MAX : duty;
      tick         = (step_cnt_q >= step_len - 27'd1);
   end

   always_comb begin
      step_cnt_d = step_cnt_q;
      duty_cnt_d = duty_cnt_q;
      pwm_d      = 1'b0;
      if (freq_off) begin
         step_cnt_d = 27'd0;
         duty_cnt_d = 10'd0;
         pwm_d      = 1'b0;
      end else begin
         step_cnt_d = tick ? 27'd0 : step_cnt_q + 27'd1;
         if (tick) begin
            duty_cnt_d = (duty_cnt_q == DUTY_LAST) ? 10'd0 : duty_cnt_q + 10'd1;
         end
         pwm_d = (duty_cnt_q < duty_eff);
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         step_cnt_q <= 27'd0;
         duty_cnt_q <= 10'd0;
         pwm_q      <= 1'b0;
      end else begin
         step_cnt_q <= step_cnt_d;
         duty_cnt_q <= duty_cnt_d;
         pwm_q      <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_cntr.sv
// tb/tb_pwm_cntr.sv - self-checking bench for pwm_cntr against a closed-form waveform model
// Runs at SYS_FREQ=1 so step lengths stay a few clocks and periods stay short.
module tb_pwm_cntr;

   localparam int SYS_FREQ = 1;

   logic        clk = 1'b0;
   logic        reset_p = 1'b1;
   logic        pwm;
   logic [13:0] pwm_freq = 14'd1000;
   logic [9:0]  duty = 10'd100;

   int checks = 0;
   int errors = 0;
   int kk = 0;
   int cur_len = 1;
   int highs;

   pwm_cntr #(
      .SYS_FREQ   (SYS_FREQ),
      .DUTY_STEPS (1000)
   ) dut (
      .clk      (clk),
      .reset_p  (reset_p),
      .pwm      (pwm),
      .pwm_freq (pwm_freq),
      .duty     (duty)
   );

   always #5 clk = ~clk;

   function automatic int len_of(input int f);
      int q;
      q = (SYS_FREQ * 1000000) / (f * 1000);
      return (q < 1) ? 1 : q;
   endfunction

   // After the k-th edge since a fresh start, pwm reflects the step index of the previous clock.
   function automatic logic ref_pwm(input int k, input int len, input int d);
      int eff;
      eff = (d >= 1000) ? 1000 : d;
      if (k < 1) return 1'b0;
      return ((((k - 1) / len) % 1000) < eff);
   endfunction

   function automatic int pick_duty();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return 1;
         2: return 999;
         3: return 1000;
         4: return 1023;
         default: return int'($urandom_range(0, 1023));
      endcase
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b at step %0d", tag, obs, exp, kk);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input int n, input bit vary, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         kk++;
         #1;
         check_bit(tag, pwm, ref_pwm(kk, cur_len, int'(duty)));
         if (pwm === 1'b1) hi++;
         if (vary && $urandom_range(0, 99) == 0) duty = 10'(pick_duty());
      end
   endtask

   task automatic start(input int f, input int d);
      reset_p  = 1'b1;
      pwm_freq = 14'(f);
      duty     = 10'(d);
      cur_len  = len_of(f);
      @(negedge clk);
      reset_p = 1'b0;
      kk = 0;
   endtask

   initial begin
      #3;
      check_bit("reset_pwm", pwm, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_bit("reset_hold", pwm, 1'b0);

      // 10 % at one-clock steps, first rise on the first edge
      start(1000, 100);
      run("basic", 1000, 1'b0, highs);
      check_int("basic_high", highs, 100);

      // servo-style duties at two-clock steps
      start(500, 50);
      run("servo50", 2000, 1'b0, highs);
      check_int("servo50_high", highs, 100);
      duty = 10'd75;
      run("servo75", 2000, 1'b0, highs);
      check_int("servo75_high", highs, 150);
      duty = 10'd100;
      run("servo100", 2000, 1'b0, highs);
      check_int("servo100_high", highs, 200);

      // duty boundaries
      start(1000, 0);
      run("duty0", 3000, 1'b0, highs);
      check_int("duty0_high", highs, 0);
      duty = 10'd1000;
      run("duty1000", 1000, 1'b0, highs);
      check_int("duty1000_high", highs, 1000);
      duty = 10'd1023;
      run("duty1023", 1000, 1'b0, highs);
      check_int("duty1023_high", highs, 1000);
      start(500, 999);
      run("duty999", 2000, 1'b0, highs);
      check_int("duty999_low", 2000 - highs, 2);

      // disabled frequency freezes counters at zero, then restarts cleanly
      pwm_freq = 14'd0;
      duty = 10'd500;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         check_bit("freq0", pwm, 1'b0);
      end
      pwm_freq = 14'd1000;
      cur_len = len_of(1000);
      kk = 0;
      run("after_freq0", 1000, 1'b0, highs);
      check_int("after_freq0_high", highs, 500);

      // asynchronous reset in the middle of a high phase
      start(500, 500);
      run("pre_reset", 300, 1'b0, highs);
      check_bit("pre_reset_high", pwm, 1'b1);
      #2;
      reset_p = 1'b1;
      #1;
      check_bit("async_reset", pwm, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_bit("reset_held", pwm, 1'b0);
      @(negedge clk);
      reset_p = 1'b0;
      kk = 0;
      run("post_reset", 2000, 1'b0, highs);
      check_int("post_reset_high", highs, 1000);

      // shrink step length mid-step: count must wrap on the next clock
      start(50, 2);
      run("fchg_pre", 10, 1'b0, highs);
      pwm_freq = 14'd250;
      cur_len = 4;
      kk = 3;
      run("fchg_post", 200, 1'b0, highs);
      check_int("fchg_high", highs, 5);

      // quotient rounds to zero and is forced to one
      start(16383, 7);
      run("fmax", 1000, 1'b0, highs);
      check_int("fmax_high", highs, 7);

      for (int s = 0; s < 6; s++) begin
         int f;
         f = int'($urandom_range(250, 2000));
         start(f, pick_duty());
         run("random", 1000 * cur_len + int'($urandom_range(0, 500)), 1'b1, highs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
